// File: rtl/pe_seq_pkg.sv
// Shared types and constants for the PE group sequencer.
package pe_seq_pkg;

    localparam int PE_LAT_DEF = 3;   // default PE input-to-p_sum latency
    localparam int LANE_W     = 8;   // width of one ifm/weight lane
    localparam int PSUM_SIG_W = 18;  // significant bits of the PE partial sum
    localparam int N_LANES    = 4;   // lanes per group

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/pe_valid_pipe.sv
// Valid-bit shift register that shadows the PE pipeline.
// `tail` marks the cycle a PE result is valid. `empty` is high when no
// valid bit sits ahead of the tail, so the pipe holds nothing beyond
// the result being committed this cycle.
module pe_valid_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_vld,
    output logic tail,
    output logic empty
);

    logic [DEPTH-1:0] pipe_q;
    logic [DEPTH-1:0] pipe_d;

    // Shift one stage per clock, feeding the accept strobe at stage 0.
    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = in_vld;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Pipe register; reset drops every in-flight valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tail = pipe_q[DEPTH-1];

    // No valid bit ahead of the tail.
    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (pipe_q[i]) begin
                empty = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pe_group_sequencer.sv
// Sequences one 4-lane MAC PE over a convolution output pixel: feeds one
// group per cycle, tracks the PE latency, accumulates partial sums and
// presents the pixel result on a valid/ready port.
// Optional feature: define PE_GROUP_SEQ_RELU_EN to clamp negative results
// to zero at the output (the accumulator itself is unaffected).
module pe_group_sequencer
    import pe_seq_pkg::*;
#(
    parameter int MAX_GROUPS = 256,
    parameter int ACC_W      = 32,
    parameter int PE_LAT     = PE_LAT_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [$clog2(MAX_GROUPS):0]   cfg_num_groups,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_ifm,
    input  logic [31:0]                   in_wgt,
    output logic [7:0]                    pe_ifm0,
    output logic [7:0]                    pe_ifm1,
    output logic [7:0]                    pe_ifm2,
    output logic [7:0]                    pe_ifm3,
    output logic [7:0]                    pe_wgt0,
    output logic [7:0]                    pe_wgt1,
    output logic [7:0]                    pe_wgt2,
    output logic [7:0]                    pe_wgt3,
    input  logic [24:0]                   pe_psum,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_W-1:0]              out_data,
    output logic                          busy
);

    localparam int CNT_W = $clog2(MAX_GROUPS) + 1;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          remaining_q, remaining_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [ACC_W-1:0]   psum_ext;
    logic                      accept;
    logic                      vld_tail;
    logic                      vld_empty;
    logic                      unused_psum_hi;

    // Negative results clamp to zero.
    function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] v);
        return v[ACC_W-1] ? '0 : v;
    endfunction

    // Bits above the significant width only repeat its sign bit.
    assign psum_ext       = {{(ACC_W-PSUM_SIG_W){pe_psum[PSUM_SIG_W-1]}}, pe_psum[PSUM_SIG_W-1:0]};
    assign unused_psum_hi = ^pe_psum[24:PSUM_SIG_W];

    pe_valid_pipe #(
        .DEPTH (PE_LAT)
    ) u_valid_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_vld (accept),
        .tail   (vld_tail),
        .empty  (vld_empty)
    );

    // Next-state, group counter, accumulator and handshake strobes.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        acc_d       = acc_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        accept      = 1'b0;
        if (vld_tail) begin
            acc_d = acc_q + psum_ext;
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    remaining_d = cfg_num_groups;
                    acc_d       = '0;
                    state_d     = (cfg_num_groups == '0) ? ST_OUT : ST_RUN;
                end
            end
            ST_RUN: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // The last add commits on this edge when nothing is ahead of it.
                if (vld_empty) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand lanes are forced to zero on cycles without an accepted beat.
    always_comb begin
        {pe_ifm3, pe_ifm2, pe_ifm1, pe_ifm0} = '0;
        {pe_wgt3, pe_wgt2, pe_wgt1, pe_wgt0} = '0;
        if (accept) begin
            {pe_ifm3, pe_ifm2, pe_ifm1, pe_ifm0} = in_ifm;
            {pe_wgt3, pe_wgt2, pe_wgt1, pe_wgt0} = in_wgt;
        end
    end

    // Result port: only driven while a result is presented.
    always_comb begin
        out_data = '0;
        if (state_q == ST_OUT) begin
`ifdef PE_GROUP_SEQ_RELU_EN
            out_data = relu(acc_q);
`else
            out_data = acc_q;
`endif
        end
    end

    assign busy = (state_q != ST_IDLE);

    // State, counter and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            acc_q       <= acc_d;
        end
    end

endmodule

// File: tb/tb_pe_group_sequencer.sv
// Self-checking bench for pe_group_sequencer with an exact 3-cycle PE model.
module tb_pe_group_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [8:0]  cfg_num_groups;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_ifm;
    logic [31:0] in_wgt;
    logic [7:0]  pe_ifm0, pe_ifm1, pe_ifm2, pe_ifm3;
    logic [7:0]  pe_wgt0, pe_wgt1, pe_wgt2, pe_wgt3;
    logic [24:0] pe_psum;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] g_ifm [64];
    logic [31:0] g_wgt [64];

    pe_group_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .cfg_num_groups (cfg_num_groups),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_ifm         (in_ifm),
        .in_wgt         (in_wgt),
        .pe_ifm0        (pe_ifm0),
        .pe_ifm1        (pe_ifm1),
        .pe_ifm2        (pe_ifm2),
        .pe_ifm3        (pe_ifm3),
        .pe_wgt0        (pe_wgt0),
        .pe_wgt1        (pe_wgt1),
        .pe_wgt2        (pe_wgt2),
        .pe_wgt3        (pe_wgt3),
        .pe_psum        (pe_psum),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural PE: exact dot product, three register stages.
    function automatic logic [24:0] pe_dot(input logic [31:0] a, input logic [31:0] b);
        int s;
        logic [7:0] x, y;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            x = a[8*k +: 8];
            y = b[8*k +: 8];
            s += int'($signed(x)) * int'($signed(y));
        end
        return s[24:0];
    endfunction

    logic [24:0] pe_p1 = '0, pe_p2 = '0, pe_p3 = '0;
    always @(posedge clk) begin
        pe_p1 <= pe_dot({pe_ifm3, pe_ifm2, pe_ifm1, pe_ifm0}, {pe_wgt3, pe_wgt2, pe_wgt1, pe_wgt0});
        pe_p2 <= pe_p1;
        pe_p3 <= pe_p2;
    end
    assign pe_psum = pe_p3;

    // Reference: the pixel result is the sum of dot products of the first n groups.
    function automatic logic [31:0] model_pixel(input int n);
        longint acc;
        logic [31:0] a, b;
        logic [7:0] x, y;
        logic [31:0] r;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            a = g_ifm[i];
            b = g_wgt[i];
            for (int k = 0; k < 4; k++) begin
                x = a[8*k +: 8];
                y = b[8*k +: 8];
                acc += longint'($signed(x)) * longint'($signed(y));
            end
        end
        r = acc[31:0];
`ifdef PE_GROUP_SEQ_RELU_EN
        if (r[31]) r = '0;
`endif
        return r;
    endfunction

    // Expected start-to-out_valid cycles with a fixed gap after every beat.
    function automatic int model_latency(input int n, input int g);
        return (n == 0) ? 1 : 1 + (n - 1) * (g + 1) + 4;
    endfunction

    function automatic int model_ready_cycles(input int n, input int g);
        return (n == 0) ? 0 : (n - 1) * (g + 1) + 1;
    endfunction

    // Drives one pixel from g_ifm/g_wgt and reports what was observed.
    task automatic run_pixel(input int n, input int g, input int hold, input bit poke,
                             output logic [31:0] res, output int lat, output int rdy_cnt,
                             output int pe_err, output bit stable, output bit post_valid,
                             output bit post_busy, output bit timeout);
        int  cyc, idx, gap_cnt;
        bit  got;
        res = '0; lat = -1; rdy_cnt = 0; pe_err = 0; stable = 1'b1;
        post_valid = 1'b1; post_busy = 1'b1; timeout = 1'b0;
        idx = 0; gap_cnt = 0; got = 1'b0;
        start = 1'b1;
        cfg_num_groups = 9'(n);
        in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!got && cyc < 3000) begin
            if (out_valid) begin
                got = 1'b1;
                lat = cyc;
                res = out_data;
            end else begin
                if (gap_cnt > 0) begin
                    in_valid = 1'b0;
                    in_ifm = $urandom;
                    in_wgt = $urandom;
                    gap_cnt--;
                end else if (idx < n) begin
                    in_valid = 1'b1;
                    in_ifm = g_ifm[idx];
                    in_wgt = g_wgt[idx];
                end else begin
                    in_valid = 1'b0;
                end
                #1;
                if (in_ready) rdy_cnt++;
                if (in_valid && in_ready) begin
                    if ({pe_ifm3, pe_ifm2, pe_ifm1, pe_ifm0} !== in_ifm ||
                        {pe_wgt3, pe_wgt2, pe_wgt1, pe_wgt0} !== in_wgt) pe_err++;
                    idx++;
                    gap_cnt = g;
                end else if ({pe_ifm3, pe_ifm2, pe_ifm1, pe_ifm0, pe_wgt3, pe_wgt2, pe_wgt1, pe_wgt0} !== 64'd0) begin
                    pe_err++;
                end
                @(posedge clk); #1;
                in_valid = 1'b0;
                cyc++;
            end
        end
        if (!got) begin
            timeout = 1'b1;
            return;
        end
        start = poke;
        cfg_num_groups = 9'd5;
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            @(posedge clk); #1;
            if (!out_valid || out_data !== res) stable = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start = 1'b0;
        post_valid = out_valid;
        post_busy = busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; cfg_num_groups = '0; in_valid = 1'b0;
        in_ifm = 32'h7f7f7f7f; in_wgt = 32'h7f7f7f7f; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if ({pe_ifm3, pe_ifm2, pe_ifm1, pe_ifm0, pe_wgt3, pe_wgt2, pe_wgt1, pe_wgt0} !== 64'd0) begin
            errors++; $display("FAIL reset_pe_lanes: got %h expected 0",
                               {pe_ifm3, pe_ifm2, pe_ifm1, pe_ifm0, pe_wgt3, pe_wgt2, pe_wgt1, pe_wgt0});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_group();
        logic [31:0] res; int lat, rdy, pe_err; bit stable, pv, pb, to;
        g_ifm[0] = {8'd4, 8'd3, 8'd2, 8'd1};
        g_wgt[0] = {8'd8, 8'd7, 8'd6, 8'd5};
        run_pixel(1, 0, 0, 1'b0, res, lat, rdy, pe_err, stable, pv, pb, to);
        checks++; if (to) begin errors++; $display("FAIL single_timeout: got no out_valid expected one"); end
        checks++; if (res !== 32'd70) begin errors++; $display("FAIL single_data: got %0d expected 70", $signed(res)); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL single_latency: got %0d expected 5", lat); end
        checks++; if (pe_err !== 0) begin errors++; $display("FAIL single_pe_lanes: got %0d bad cycles expected 0", pe_err); end
        checks++; if (pv !== 1'b0 || pb !== 1'b0) begin errors++; $display("FAIL single_return_idle: got valid=%b busy=%b expected 0 0", pv, pb); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res; int lat, rdy, pe_err; bit stable, pv, pb, to;
        for (int i = 0; i < 3; i++) begin g_ifm[i] = {4{8'h80}}; g_wgt[i] = {4{8'h80}}; end
        run_pixel(3, 0, 0, 1'b0, res, lat, rdy, pe_err, stable, pv, pb, to);
        checks++; if (to) begin errors++; $display("FAIL b2b_timeout: got no out_valid expected one"); end
        checks++; if (res !== 32'd196608) begin errors++; $display("FAIL b2b_data: got %0d expected 196608", $signed(res)); end
        checks++; if (rdy !== 3) begin errors++; $display("FAIL b2b_in_ready_cycles: got %0d expected 3", rdy); end
        checks++; if (lat !== 7) begin errors++; $display("FAIL b2b_latency: got %0d expected 7", lat); end
        checks++; if (pe_err !== 0) begin errors++; $display("FAIL b2b_pe_lanes: got %0d bad cycles expected 0", pe_err); end
    endtask

    task automatic test_bubbles_backpressure();
        logic [31:0] res, exp_res; int lat, rdy, pe_err; bit stable, pv, pb, to;
        for (int i = 0; i < 4; i++) begin g_ifm[i] = {4{8'hfd}}; g_wgt[i] = {4{8'd7}}; end
`ifdef PE_GROUP_SEQ_RELU_EN
        exp_res = 32'd0;
`else
        exp_res = -32'sd336;
`endif
        run_pixel(4, 1, 5, 1'b1, res, lat, rdy, pe_err, stable, pv, pb, to);
        checks++; if (to) begin errors++; $display("FAIL bubble_timeout: got no out_valid expected one"); end
        checks++; if (res !== exp_res) begin errors++; $display("FAIL bubble_data: got %0d expected %0d", $signed(res), $signed(exp_res)); end
        checks++; if (lat !== 11) begin errors++; $display("FAIL bubble_latency: got %0d expected 11", lat); end
        checks++; if (rdy !== 7) begin errors++; $display("FAIL bubble_in_ready_cycles: got %0d expected 7", rdy); end
        checks++; if (pe_err !== 0) begin errors++; $display("FAIL bubble_pe_lanes: got %0d bad cycles expected 0", pe_err); end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL bubble_hold_stable: got %b expected 1", stable); end
        checks++; if (pv !== 1'b0 || pb !== 1'b0) begin errors++; $display("FAIL bubble_start_ignored: got valid=%b busy=%b expected 0 0", pv, pb); end
    endtask

    task automatic test_zero_groups();
        logic [31:0] res; int lat, rdy, pe_err; bit stable, pv, pb, to;
        run_pixel(0, 0, 2, 1'b0, res, lat, rdy, pe_err, stable, pv, pb, to);
        checks++; if (to) begin errors++; $display("FAIL zero_timeout: got no out_valid expected one"); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL zero_latency: got %0d expected 1", lat); end
        checks++; if (res !== 32'd0) begin errors++; $display("FAIL zero_data: got %0d expected 0", $signed(res)); end
        checks++; if (rdy !== 0) begin errors++; $display("FAIL zero_in_ready_cycles: got %0d expected 0", rdy); end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL zero_hold_stable: got %b expected 1", stable); end
    endtask

    task automatic test_reset_mid_stream();
        logic [31:0] res; int lat, rdy, pe_err; bit stable, pv, pb, to;
        start = 1'b1; cfg_num_groups = 9'd2;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; in_ifm = {4{8'd100}}; in_wgt = {4{8'd100}};
        @(posedge clk); #1;
        in_ifm = {4{8'd90}}; in_wgt = {4{8'd90}};
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Now in DRAIN with two results inside the PE.
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_ctrl: got ready=%b valid=%b busy=%b expected 0 0 0", in_ready, out_valid, busy);
        end
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL midreset_out_data: got %0d expected 0", out_data); end
        checks++; if ({pe_ifm3, pe_ifm2, pe_ifm1, pe_ifm0, pe_wgt3, pe_wgt2, pe_wgt1, pe_wgt0} !== 64'd0) begin
            errors++; $display("FAIL midreset_pe_lanes: got nonzero expected 0");
        end
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        g_ifm[0] = {4{8'd2}}; g_wgt[0] = {4{8'd2}};
        run_pixel(1, 0, 0, 1'b0, res, lat, rdy, pe_err, stable, pv, pb, to);
        checks++; if (to) begin errors++; $display("FAIL midreset_timeout: got no out_valid expected one"); end
        checks++; if (res !== 32'd16) begin errors++; $display("FAIL midreset_next_data: got %0d expected 16", $signed(res)); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL midreset_next_latency: got %0d expected 5", lat); end
    endtask

    task automatic test_random();
        logic [31:0] res, exp_res; int lat, rdy, pe_err; bit stable, pv, pb, to;
        int n, g, hold;
        for (int p = 0; p < 8; p++) begin
            n = $urandom_range(0, 12);
            g = $urandom_range(0, 2);
            hold = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) begin g_ifm[i] = $urandom; g_wgt[i] = $urandom; end
            exp_res = model_pixel(n);
            run_pixel(n, g, hold, p[0], res, lat, rdy, pe_err, stable, pv, pb, to);
            checks++; if (to) begin errors++; $display("FAIL rand_timeout: pixel %0d got no out_valid expected one", p); end
            checks++; if (res !== exp_res) begin errors++; $display("FAIL rand_data: pixel %0d n=%0d got %0d expected %0d", p, n, $signed(res), $signed(exp_res)); end
            checks++; if (lat !== model_latency(n, g)) begin errors++; $display("FAIL rand_latency: pixel %0d got %0d expected %0d", p, lat, model_latency(n, g)); end
            checks++; if (rdy !== model_ready_cycles(n, g)) begin errors++; $display("FAIL rand_in_ready_cycles: pixel %0d got %0d expected %0d", p, rdy, model_ready_cycles(n, g)); end
            checks++; if (pe_err !== 0) begin errors++; $display("FAIL rand_pe_lanes: pixel %0d got %0d bad cycles expected 0", p, pe_err); end
            checks++; if (stable !== 1'b1 || pv !== 1'b0 || pb !== 1'b0) begin
                errors++; $display("FAIL rand_handshake: pixel %0d got stable=%b valid=%b busy=%b expected 1 0 0", p, stable, pv, pb);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_group();
        test_back_to_back();
        test_bubbles_backpressure();
        test_zero_groups();
        test_reset_mid_stream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
